// File: rtl/wait_state_mem.sv
// Data-memory responder that answers each LSU request after WAIT_CYCLES wait
// states with a one-cycle ready pulse; out-of-range accesses return an error.
module wait_state_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        err_o
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   wd_q;
    logic          oor_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          capture, enter_resp;
    logic          in_oor;
    logic [AW-1:0] acc_idx;
    logic          acc_we, acc_oor;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wd;

    // 33-bit compare so DEPTH_WORDS*4 cannot overflow for large depths
    assign in_oor = ({1'b0, addr_i} >= LIMIT);

    // With zero wait states the access commits on the capture edge itself,
    // so the pins are used directly in IDLE and the captured copy elsewhere.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_idx = addr_i[AW+1:2];
            acc_we  = write_enable_i;
            acc_be  = byte_enable_i;
            acc_wd  = write_data_i;
            acc_oor = in_oor;
        end else begin
            acc_idx = idx_q;
            acc_we  = we_q;
            acc_be  = be_q;
            acc_wd  = wd_q;
            acc_oor = oor_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req_i) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wd_q    <= 32'd0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q <= addr_i[AW+1:2];
                we_q  <= write_enable_i;
                be_q  <= byte_enable_i;
                wd_q  <= write_data_i;
                oor_q <= in_oor;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rdata_q <= 32'd0;
        end else if (enter_resp && !acc_we) begin
            rdata_q <= acc_oor ? ERR_DATA : mem_q[acc_idx];
        end
    end

    // RAM is never cleared; a reset edge suppresses the commit of an aborted write
    always_ff @(posedge clk_i) begin
        if (rst_i && enter_resp && acc_we && !acc_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) mem_q[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
            end
        end
    end

    assign read_data_o = rdata_q;
    assign ready_o     = (state_q == S_RESP);
    assign err_o       = (state_q == S_RESP) && oor_q;

endmodule

// File: tb/tb_wait_state_mem.sv
// Bench for wait_state_mem: a 2-wait-state and a 0-wait-state instance checked
// against an array model of the memory and the latency rules.
module tb_wait_state_mem;
    localparam int W0 = 2;
    localparam int W1 = 0;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [2];
    logic        we_s   [2];
    logic [3:0]  be_s   [2];
    logic [31:0] addr_s [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rd     [2];
    logic        rdy    [2];
    logic        err    [2];

    logic [31:0] mem_m [2][1024];
    logic [31:0] rd_m  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wait_state_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0), .ERR_DATA(ERR)) u_dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .write_enable_i(we_s[0]),
        .byte_enable_i(be_s[0]), .addr_i(addr_s[0]), .write_data_i(wd_s[0]),
        .read_data_o(rd[0]), .ready_o(rdy[0]), .err_o(err[0]));

    wait_state_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1), .ERR_DATA(ERR)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .write_enable_i(we_s[1]),
        .byte_enable_i(be_s[1]), .addr_i(addr_s[1]), .write_data_i(wd_s[1]),
        .read_data_o(rd[1]), .ready_o(rdy[1]), .err_o(err[1]));

    function automatic int wv(input int z);
        return (z == 0) ? W0 : W1;
    endfunction

    // Model: word memory with per-lane writes, held read data, error on >= 4 KiB.
    task automatic model_op(input int z, input logic w, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] exp_rd, output logic exp_err);
        exp_err = (a >= 32'h0000_1000);
        if (w) begin
            if (!exp_err)
                for (int b = 0; b < 4; b++)
                    if (be[b]) mem_m[z][a[11:2]][8*b +: 8] = wd[8*b +: 8];
        end else begin
            rd_m[z] = exp_err ? ERR : mem_m[z][a[11:2]];
        end
        exp_rd = rd_m[z];
    endtask

    // One request; pins are scrambled right after capture. Starts and ends in IDLE.
    task automatic do_access(input int z, input logic w, input logic [3:0] be,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [41:0] got);
        int lat;
        logic [31:0] r;
        logic e, tail;
        req[z] = 1'b1; we_s[z] = w; be_s[z] = be; addr_s[z] = a; wd_s[z] = wd;
        @(posedge clk); #1;
        req[z] = 1'b0; we_s[z] = 1'($urandom); be_s[z] = 4'($urandom);
        addr_s[z] = $urandom; wd_s[z] = $urandom;
        lat = 1;
        while (!rdy[z] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = rd[z]; e = err[z];
        @(posedge clk); #1;
        tail = rdy[z] | err[z];
        got = {8'(lat), r, e, tail};
    endtask

    task automatic op_check(input string name, input int z, input logic w,
                            input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
        logic [41:0] got, exp;
        logic [31:0] er;
        logic ee;
        model_op(z, w, be, a, wd, er, ee);
        do_access(z, w, be, a, wd, got);
        exp = {8'(wv(z) + 1), er, ee, 1'b0};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d {lat,rdata,err,tail} got=%h exp=%h", name, z, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int z = 0; z < 2; z++) begin
            req[z] = 1'b0; we_s[z] = 1'b0; be_s[z] = 4'h0; addr_s[z] = 32'h0; wd_s[z] = 32'h0;
            rd_m[z] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int z = 0; z < 2; z++) begin
            total++;
            if ({rdy[z], err[z], rd[z]} !== 34'h0) begin
                bad++;
                $display("FAIL reset dut%0d {ready,err,rdata} got=%h exp=0", z, {rdy[z], err[z], rd[z]});
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        op_check("basic_wr", 0, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
        op_check("basic_rd", 0, 1'b0, 4'hF, 32'h10, 32'h0);
    endtask

    task automatic test_byte_lanes();
        op_check("lane_pre", 0, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
        op_check("lane_wr",  0, 1'b1, 4'b0101, 32'h20, 32'h1122_3344);
        op_check("lane_rd",  0, 1'b0, 4'hF, 32'h20, 32'h0);
        op_check("be0_wr",   0, 1'b1, 4'b0000, 32'h20, 32'h5555_5555);
        op_check("be0_rd",   0, 1'b0, 4'hF, 32'h20, 32'h0);
        total++;
        if (mem_m[0][8] !== 32'hAA22_CC44) begin
            bad++;
            $display("FAIL lane_model got=%h exp=aa22cc44", mem_m[0][8]);
        end
    endtask

    task automatic test_out_of_range();
        op_check("oor_pre0", 0, 1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);
        op_check("oor_rd",   0, 1'b0, 4'hF, 32'h1000, 32'h0);
        op_check("oor_wr",   0, 1'b1, 4'hF, 32'h1000, 32'h0BAD_0BAD);
        op_check("oor_rd0",  0, 1'b0, 4'hF, 32'h0, 32'h0);
        op_check("oor_top",  0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
        op_check("oor_last", 0, 1'b0, 4'hF, 32'h0FFC, 32'h0);
    endtask

    task automatic test_wait_inputs();
        op_check("win_wa", 0, 1'b1, 4'hF, 32'h30, 32'h0A0A_0A0A);
        op_check("win_wb", 0, 1'b1, 4'hF, 32'h34, 32'hB0B0_B0B0);
        op_check("win_ra", 0, 1'b0, 4'hF, 32'h30, 32'h0);
        op_check("win_rb", 0, 1'b0, 4'hF, 32'h34, 32'h0);
    endtask

    task automatic test_zero_wait();
        logic [9:0] pat;
        op_check("zw_wr", 1, 1'b1, 4'hF, 32'h40, 32'h5A5A_A5A5);
        op_check("zw_rd", 1, 1'b0, 4'hF, 32'h40, 32'h0);
        req[1] = 1'b1; we_s[1] = 1'b0; be_s[1] = 4'hF; addr_s[1] = 32'h40;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            pat[k] = rdy[1];
            if (k == 9) req[1] = 1'b0;
        end
        total++;
        if (pat !== 10'b01_0101_0101) begin
            bad++;
            $display("FAIL zero_wait_pattern got=%b exp=0101010101", pat);
        end
        total++;
        if (rd[1] !== 32'h5A5A_A5A5) begin
            bad++;
            $display("FAIL zero_wait_data got=%h exp=5a5aa5a5", rd[1]);
        end
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        op_check("rmw_pre", 0, 1'b1, 4'hF, 32'h08, 32'h0);
        op_check("rmw_rd0", 0, 1'b0, 4'hF, 32'h34, 32'h0);
        req[0] = 1'b1; we_s[0] = 1'b1; be_s[0] = 4'hF; addr_s[0] = 32'h08; wd_s[0] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req[0] = 1'b0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen |= rdy[0]; end
        rst = 1'b1;
        rd_m[0] = 32'h0; rd_m[1] = 32'h0;
        repeat (4) begin @(posedge clk); #1; seen |= rdy[0]; end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rmw_no_ready got=%b exp=0", seen);
        end
        total++;
        if (rd[0] !== 32'h0) begin
            bad++;
            $display("FAIL rmw_rdata_reset got=%h exp=0", rd[0]);
        end
        op_check("rmw_rd", 0, 1'b0, 4'hF, 32'h08, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r;
        int idx;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'hFFFF_FFFC;
        if (r < 3) return 32'h1000 + ($urandom & 32'h00FF_FFFF);
        idx = $urandom_range(0, 31);
        if (idx >= 16) idx += 992;
        return {20'h0, 10'(idx), 2'($urandom)};
    endfunction

    task automatic test_random();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 32; i++)
                op_check("rnd_pre", z, 1'b1, 4'hF, {20'h0, 10'(i < 16 ? i : i + 992), 2'b00}, $urandom);
            for (int i = 0; i < 50; i++)
                op_check("rnd_op", z, 1'($urandom), 4'($urandom), pick_addr(), $urandom);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_out_of_range();
        test_wait_inputs();
        test_zero_wait();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wait_state_mem.md
Name: wait_state_mem

Overview:
- Memory-side responder for the LSU data-memory interface: accepts `mem_req_i` with write enable, byte enables, address and write data, then completes after a programmable number of wait states with a one-cycle `ready_o`.
- Sits behind the LSU in place of the zero-latency data memory, so that the core stall path can be exercised against variable memory latency.
- Holds a word-organised RAM. Out-of-range accesses get a fixed error response.

Parameters:
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 2: wait states between request capture and `ready_o`; range 0..15.
- ERR_DATA, 32'hDEAD_BEEF: read data returned for out-of-range reads.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-low (0 = reset).
- mem_req_i  in  1  access request; sampled only in IDLE.
- write_enable_i  in  1  1 = write, 0 = read.
- byte_enable_i  in  4  byte lane write mask; bit n covers data[8n+7:8n].
- addr_i  in  32  byte address; addr_i[1:0] ignored.
- write_data_i  in  32  write data.
- read_data_o  out  32  read result; valid while `ready_o`=1; held until the next read completes.
- ready_o  out  1  one-cycle completion pulse.
- err_o  out  1  pulses together with `ready_o` when the address is out of range.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to IDLE; wait counter = 0.
  - `ready_o`=0, `err_o`=0, `read_data_o`=32'h0.
  - RAM contents are not cleared.
  - Any in-flight access is aborted; a pending write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `mem_req_i`=1, capture addr, we, be, wd and the range check (addr_i >= DEPTH_WORDS*4 → out of range).
  - Go to WAIT with counter=WAIT_CYCLES when WAIT_CYCLES>0; otherwise go straight to RESP.
  - If `mem_req_i`=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next state is RESP.
  - Input pins are ignored in WAIT; only the captured values are used.
- RESP transition edge (the edge entering RESP):
  - Write, in range: update RAM[addr[log2(DEPTH_WORDS)+1:2]] only for lanes with be=1.
  - Read, in range: load `read_data_o` from RAM.
  - Read, out of range: load `read_data_o` with ERR_DATA.
  - Write, out of range: discarded; RAM unchanged.
  - On writes, `read_data_o` is unchanged.
- RESP:
  - `ready_o`=1 for exactly this cycle; `err_o`=captured out-of-range flag.
  - Next state is always IDLE; `mem_req_i` is ignored in RESP.
- Latency: with the request sampled in IDLE at cycle T, `ready_o` is high in cycle T+WAIT_CYCLES+1.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
  - A requester holding `mem_req_i` high continuously is re-sampled in the first IDLE cycle after RESP.
- byte_enable_i=4'b0000 on a write: no lanes change; `ready_o` still pulses.
- Read-after-write to the same word in consecutive transactions returns the new data; no bypass is needed because the write commits before IDLE.
- Address wrap: none. Any address >= DEPTH_WORDS*4 is an error, including 32'hFFFF_FFFC.
- Reset asserted in WAIT or RESP: state returns to IDLE next edge; `ready_o` low from the following cycle.

Test Plan:
- Reset, then WAIT_CYCLES=2: write 32'h1234_5678 to 0x10 with be=4'hF, then read 0x10 → `ready_o` high exactly 3 cycles after each request sample; read_data_o=32'h1234_5678; err_o=0.
- Byte lanes: preload 0x20=32'hAABB_CCDD, write 32'h1122_3344 with be=4'b0101, read back → 32'hAA22_CC44.
- Out of range: DEPTH_WORDS=1024, read 0x1000 → read_data_o=32'hDEAD_BEEF with err_o=1 and ready_o=1 in the same cycle. Write 0x1000 then read 0x0000 → word 0 unchanged.
- Zero wait: WAIT_CYCLES=0, `mem_req_i` held high for back-to-back reads → ready_o pulses every 2nd cycle; never two consecutive cycles high.
- Reset mid-write: write 32'hFFFF_FFFF to 0x08 (old 32'h0), assert rst_i=0 during WAIT → no ready_o pulse; after release, read 0x08 → 32'h0.
- Inputs during WAIT: change addr_i/write_data_i while in WAIT → the originally captured address and data are used.
